// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the sequential Booth multiplier.
//   - state_t    : FSM state encoding (IDLE, RUN, DONE)
//   - WIDTH_DEF  : default operand/result width
//   - STEPS_DEF  : default Booth iterations per multiply (equals width)
//   - cnt_width  : step-counter width able to hold 0..steps
//   - CNT_W      : counter width for the default configuration (6 for 32)
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned STEPS_DEF = 32;

    function automatic int unsigned cnt_width(input int unsigned steps);
        return $clog2(steps + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(STEPS_DEF);

endpackage

// File: rtl/cla_adder.sv
// cla_adder: carry-lookahead adder, sum = a + b + cin (carry-out dropped).
//   a, b : WIDTH-bit addends
//   cin  : carry in (used as the +1 of a two's complement subtract)
//   sum  : WIDTH-bit sum
// Bits are grouped in 4-bit generate/propagate cells; the carry between
// groups is produced from the group generate/propagate terms, the last
// group may be partial when WIDTH is not a multiple of 4.
module cla_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum
);

    localparam int unsigned GRP  = 4;
    localparam int unsigned NGRP = (WIDTH + GRP - 1) / GRP;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic             grp_carry;
    logic             grp_g;
    logic             grp_p;
    logic             bit_c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        sum       = '0;
        grp_carry = cin;
        grp_g     = 1'b0;
        grp_p     = 1'b1;
        bit_c     = 1'b0;
        for (int unsigned gi = 0; gi < NGRP; gi++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            bit_c = grp_carry;
            for (int unsigned j = gi * GRP; (j < gi * GRP + GRP) && (j < WIDTH); j++) begin
                sum[j] = p[j] ^ bit_c;
                bit_c  = g[j] | (p[j] & bit_c);
                grp_g  = g[j] | (p[j] & grp_g);
                grp_p  = grp_p & p[j];
            end
            // Group carry-out from lookahead terms, not from the bit chain.
            grp_carry = grp_g | (grp_p & grp_carry);
        end
    end

endmodule

// File: rtl/mult_seq.sv
// mult_seq: signed sequential radix-2 Booth multiplier, one step per clock.
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset
//   ctrl_start : start request, accepted in IDLE or DONE
//   data_a     : signed multiplicand, sampled with an accepted start
//   data_b     : signed multiplier, sampled with an accepted start
//   result     : low WIDTH bits of the product, held until the next result
//   result_rdy : one-cycle pulse while result/overflow are fresh
//   overflow   : product does not fit in signed WIDTH bits
//   busy       : high while a multiply is running
module mult_seq
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned STEPS = STEPS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] result,
    output logic             result_rdy,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned    CW        = cnt_width(STEPS);
    localparam logic [CW-1:0]  LAST_STEP = CW'(STEPS - 1);

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [2*WIDTH:0]   p_reg;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_inc;

    logic [WIDTH:0]     hi_ext;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     addend;
    logic               add_cin;
    logic [WIDTH:0]     hi_sum;
    logic [2*WIDTH:0]   p_next;
    logic               ovf_next;

    // Upper half of P widened by one sign bit so that subtracting the most
    // negative multiplicand cannot wrap inside the accumulator.
    assign hi_ext = {p_reg[2*WIDTH], p_reg[2*WIDTH:WIDTH+1]};
    assign m_ext  = {m_reg[WIDTH-1], m_reg};

    always_comb begin
        addend  = '0;
        add_cin = 1'b0;
        unique case (p_reg[1:0])
            2'b01: begin
                addend  = m_ext;
                add_cin = 1'b0;
            end
            2'b10: begin
                addend  = ~m_ext;
                add_cin = 1'b1;
            end
            default: begin
                addend  = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    cla_adder #(.WIDTH(WIDTH + 1)) u_acc_add (
        .a   (hi_ext),
        .b   (addend),
        .cin (add_cin),
        .sum (hi_sum)
    );

    cla_adder #(.WIDTH(CW)) u_cnt_inc (
        .a   (cnt),
        .b   ('0),
        .cin (1'b1),
        .sum (cnt_inc)
    );

    // The WIDTH+1-bit sum becomes the top of P, which realises the
    // arithmetic right shift without a separate sign-replication step.
    assign p_next = {hi_sum, p_reg[WIDTH:1]};

    // Product is p_next[2W:1]; its bits [2W-1:W-1] map to p_next[2W:W].
    assign ovf_next = ~((&p_next[2*WIDTH:WIDTH]) | ~(|p_next[2*WIDTH:WIDTH]));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            p_reg      <= '0;
            m_reg      <= '0;
            result     <= '0;
            overflow   <= 1'b0;
            result_rdy <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    result_rdy <= 1'b0;
                    if (ctrl_start) begin
                        m_reg <= data_a;
                        p_reg <= {{WIDTH{1'b0}}, data_b, 1'b0};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    p_reg <= p_next;
                    cnt   <= cnt_inc;
                    if (cnt == LAST_STEP) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        result_rdy <= 1'b1;
                        result     <= p_next[WIDTH:1];
                        overflow   <= ovf_next;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    result_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
